// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the receive-path packet framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default header bytes, counter widths and a
// small header-classification helper used by the framer.
package pkt_rx_pkg;

  // Framer states: hunting for a header, or counting data bits.
  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

  // Default header bytes; the framer takes them as parameters so a board
  // variant can re-key the protocol without touching the logic.
  localparam logic [7:0] HDR_A_DEF = 8'hA5;
  localparam logic [7:0] HDR_B_DEF = 8'hC3;

  // Byte counter covers up to 16 data bytes per packet.
  localparam int BYTE_CNT_W = 4;
  // Gap timer covers idle runs up to 65535 clocks.
  localparam int GAP_W      = 16;

  typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;
  typedef logic [GAP_W-1:0]      gap_cnt_t;

  // Result of classifying one window of the shift register.
  typedef struct packed {
    logic hit;    // window holds one of the two header bytes
    logic is_b;   // 0: first header byte, 1: second header byte
  } hdr_match_t;

  // Header A is tested first so it wins when both keys are configured
  // to the same value.
  function automatic hdr_match_t hdr_classify(
    input logic [7:0] window,
    input logic [7:0] hdr_a,
    input logic [7:0] hdr_b
  );
    hdr_match_t m;
    m.hit  = 1'b0;
    m.is_b = 1'b0;
    if (window == hdr_a) begin
      m.hit  = 1'b1;
      m.is_b = 1'b0;
    end else if (window == hdr_b) begin
      m.hit  = 1'b1;
      m.is_b = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Purpose: saturating idle-clock counter with clear and terminal-count pulse.
// Latency: tc is combinational from the count register and the current inputs.
// Backpressure: none; counts every enabled clock, holds at GAP_MAX.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (count -> 0)
//   clr    in   clear count to 0 (wins over en)
//   en     in   count this clock
//   tc     out  high while count == GAP_MAX, en=1 and clr=0
//   cnt    out  current count
module pkt_gap_timer
  import pkt_rx_pkg::*;
#(
  parameter int unsigned GAP_MAX = 255
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     en,
  output logic     tc,
  output gap_cnt_t cnt
);

  localparam gap_cnt_t MAX_C = gap_cnt_t'(GAP_MAX);

  gap_cnt_t cnt_q;
  gap_cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + gap_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear arriving on the terminal cycle suppresses the pulse, so fresh
  // activity on the last allowed clock never reports a timeout.
  assign tc  = en && !clr && (cnt_q == MAX_C);
  assign cnt = cnt_q;

endmodule

// File: rtl/pkt_rx_ctrl.sv
// Purpose: frames header-led packets out of an external serial-to-parallel shift register.
// Latency: bit_valid at t -> match/count at t+1 -> registered outputs visible at t+2.
// Backpressure: none; the shift register never stalls and bytes are strobed unconditionally.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset, highest priority
//   bit_valid      in   serial bit on the shift register input this cycle
//   parallel_data  in   [7:0] shift register output
//   shift_ena      out  shift enable, equal to bit_valid (only combinational path)
//   byte_strobe    out  one-cycle pulse, byte_out/byte_idx valid
//   byte_out       out  [7:0] captured data byte
//   byte_idx       out  [3:0] position of byte_out inside the packet
//   hdr_type       out  0: header A packet, 1: header B packet (held)
//   pkt_done       out  one-cycle pulse alongside the last byte_strobe
//   pkt_err        out  one-cycle pulse when an inter-bit gap times out
//   busy           out  high while framing data bytes
module pkt_rx_ctrl
  import pkt_rx_pkg::*;
#(
  parameter logic [7:0]  HDR_A   = HDR_A_DEF,
  parameter logic [7:0]  HDR_B   = HDR_B_DEF,
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned GAP_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic [7:0] parallel_data,
  output logic       shift_ena,
  output logic       byte_strobe,
  output logic [7:0] byte_out,
  output logic [3:0] byte_idx,
  output logic       hdr_type,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       busy
);

  localparam byte_cnt_t LAST_BYTE = byte_cnt_t'(NBYTES - 1);

  // The shift register updates on the same edge that registers bit_valid,
  // so ena_q marks the first cycle the new bit is visible on parallel_data.
  logic       ena_q;

  state_e     state_q,       state_d;
  logic [2:0] bit_cnt_q,     bit_cnt_d;
  byte_cnt_t  byte_cnt_q,    byte_cnt_d;
  logic [7:0] byte_out_q,    byte_out_d;
  byte_cnt_t  byte_idx_q,    byte_idx_d;
  logic       hdr_type_q,    hdr_type_d;
  logic       byte_strobe_q, byte_strobe_d;
  logic       pkt_done_q,    pkt_done_d;
  logic       pkt_err_q,     pkt_err_d;

  logic       gap_clr;
  logic       gap_tc;
  gap_cnt_t   gap_cnt;
  hdr_match_t hdr_m;

  assign shift_ena = bit_valid;

  // Idle clocks only matter inside a packet; any fresh bit restarts the run.
  assign gap_clr = (state_q == HUNT) || ena_q;

  pkt_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (gap_clr),
    .en    (1'b1),
    .tc    (gap_tc),
    .cnt   (gap_cnt)
  );

  assign hdr_m = hdr_classify(parallel_data, HDR_A, HDR_B);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_out_d    = byte_out_q;
    byte_idx_d    = byte_idx_q;
    hdr_type_d    = hdr_type_q;
    byte_strobe_d = 1'b0;
    pkt_done_d    = 1'b0;
    pkt_err_d     = 1'b0;

    case (state_q)
      HUNT: begin
        // Sliding-window search: every new bit re-tests the full byte.
        if (ena_q && hdr_m.hit) begin
          state_d    = DATA;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          hdr_type_d = hdr_m.is_b;
        end
      end

      DATA: begin
        if (ena_q) begin
          // Header bytes are ordinary payload here; only bit position counts.
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d    = parallel_data;
            byte_idx_d    = byte_cnt_q;
            byte_strobe_d = 1'b1;
            byte_cnt_d    = byte_cnt_q + byte_cnt_t'(1);
            if (byte_cnt_q == LAST_BYTE) begin
              // Search resumes from the next bit; the window still holds
              // this byte but HUNT only takes effect next clock.
              pkt_done_d = 1'b1;
              state_d    = HUNT;
            end
          end
        end else if (gap_tc) begin
          // Partial byte is dropped without a strobe.
          pkt_err_d = 1'b1;
          state_d   = HUNT;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ena_q         <= 1'b0;
      state_q       <= HUNT;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      byte_out_q    <= 8'h00;
      byte_idx_q    <= '0;
      hdr_type_q    <= 1'b0;
      byte_strobe_q <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      ena_q         <= bit_valid;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_out_q    <= byte_out_d;
      byte_idx_q    <= byte_idx_d;
      hdr_type_q    <= hdr_type_d;
      byte_strobe_q <= byte_strobe_d;
      pkt_done_q    <= pkt_done_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign byte_strobe = byte_strobe_q;
  assign byte_out    = byte_out_q;
  assign byte_idx    = byte_idx_q;
  assign hdr_type    = hdr_type_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_err     = pkt_err_q;
  assign busy        = (state_q == DATA);

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Purpose: self-checking bench for pkt_rx_ctrl with a serial shift register model.
// Latency: compares every cycle against a packet-level reference model.
// Backpressure: n/a.
module tb_pkt_rx_ctrl;

  localparam int NB = 4;
  localparam int GM = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_valid = 1'b0;
  logic       ser_bit = 1'b0;
  logic [7:0] sr = 8'h00;

  logic       shift_ena;
  logic       byte_strobe;
  logic [7:0] byte_out;
  logic [3:0] byte_idx;
  logic       hdr_type;
  logic       pkt_done;
  logic       pkt_err;
  logic       busy;

  always #5 clk = ~clk;

  // Environment shift register: MSB-first serial in, new bit enters the LSB.
  always @(posedge clk) if (bit_valid) sr <= {sr[6:0], ser_bit};

  pkt_rx_ctrl #(
    .HDR_A   (8'hA5),
    .HDR_B   (8'hC3),
    .NBYTES  (NB),
    .GAP_MAX (GM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_valid     (bit_valid),
    .parallel_data (sr),
    .shift_ena     (shift_ena),
    .byte_strobe   (byte_strobe),
    .byte_out      (byte_out),
    .byte_idx      (byte_idx),
    .hdr_type      (hdr_type),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .busy          (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: tracks the bit stream the link carried and frames it.
  logic       prev_bv = 1'b0, prev_b = 1'b0, prev_rst = 1'b1;
  logic [7:0] m_hist = 8'h00;
  bit         m_in_pkt = 1'b0;
  bit         m_bits[$];
  int         m_nbytes = 0;
  int         m_low = 0;
  logic       e_strobe = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_hdr = 1'b0;
  logic [7:0] e_byte = 8'h00;
  logic [3:0] e_idx = 4'h0;

  // Per-scenario observations of the DUT.
  int         cyc_no = 0;
  int         n_strobe = 0, n_done = 0, n_err = 0;
  int         first_idx = -1;
  logic [7:0] done_byte = 8'h00;
  int         strobe_cyc[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic rst);
    logic ena;
    logic [7:0] v;
    e_strobe = 1'b0;
    e_done   = 1'b0;
    e_err    = 1'b0;
    ena = prev_bv && !prev_rst;
    if (prev_bv) m_hist = {m_hist[6:0], prev_b};
    if (rst) begin
      m_in_pkt = 1'b0;
      m_bits.delete();
      m_nbytes = 0;
      m_low = 0;
      e_byte = 8'h00;
      e_idx = 4'h0;
      e_hdr = 1'b0;
      e_busy = 1'b0;
      return;
    end
    if (!m_in_pkt) begin
      if (ena && (m_hist == 8'hA5 || m_hist == 8'hC3)) begin
        m_in_pkt = 1'b1;
        e_hdr = (m_hist != 8'hA5);
        m_bits.delete();
        m_nbytes = 0;
        m_low = 0;
      end
    end else if (ena) begin
      m_low = 0;
      m_bits.push_back(prev_b);
      if (m_bits.size() == 8) begin
        v = 8'h00;
        foreach (m_bits[i]) v = {v[6:0], m_bits[i]};
        e_strobe = 1'b1;
        e_byte = v;
        e_idx = 4'(m_nbytes);
        m_nbytes++;
        m_bits.delete();
        if (m_nbytes == NB) begin
          e_done = 1'b1;
          m_in_pkt = 1'b0;
        end
      end
    end else begin
      m_low++;
      if (m_low == GM + 1) begin
        e_err = 1'b1;
        m_in_pkt = 1'b0;
      end
    end
    e_busy = m_in_pkt;
  endtask

  task automatic step(input logic bv, input logic b, input logic rst);
    bit_valid = bv;
    ser_bit = b;
    reset = rst;
    #1;
    chk("shift_ena", 16'(shift_ena), 16'(bv));
    model_update(rst);
    prev_bv = bv;
    prev_b = b;
    prev_rst = rst;
    @(posedge clk);
    #1;
    cyc_no++;
    chk("byte_strobe", 16'(byte_strobe), 16'(e_strobe));
    chk("pkt_done", 16'(pkt_done), 16'(e_done));
    chk("pkt_err", 16'(pkt_err), 16'(e_err));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("hdr_type", 16'(hdr_type), 16'(e_hdr));
    chk("byte_out", 16'(byte_out), 16'(e_byte));
    chk("byte_idx", 16'(byte_idx), 16'(e_idx));
    if (byte_strobe) begin
      n_strobe++;
      strobe_cyc.push_back(cyc_no);
      if (first_idx < 0) first_idx = int'(byte_idx);
    end
    if (pkt_done) begin
      n_done++;
      done_byte = byte_out;
    end
    if (pkt_err) n_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      int g;
      step(1'b1, v[i], 1'b0);
      if (gap > 0) begin
        g = $urandom_range(gap, 0);
        repeat (g) step(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic scen_begin();
    n_strobe = 0;
    n_done = 0;
    n_err = 0;
    first_idx = -1;
    strobe_cyc.delete();
  endtask

  initial begin
    // Reset state.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    idle(2);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_byte_out", 16'(byte_out), 16'h00);
    chk("rst_strobe", 16'(byte_strobe), 16'd0);

    // Header A, continuous bits.
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    idle(4);
    chk("s1_strobes", 16'(n_strobe), 16'd4);
    chk("s1_done", 16'(n_done), 16'd1);
    chk("s1_done_byte", 16'(done_byte), 16'h44);
    chk("s1_hdr", 16'(hdr_type), 16'd0);
    chk("s1_first_idx", 16'(first_idx), 16'd0);
    for (int i = 1; i < strobe_cyc.size(); i++)
      chk("s1_spacing", 16'(strobe_cyc[i] - strobe_cyc[i-1]), 16'd8);

    // Header B, random 0..5 clock gaps between bits.
    scen_begin();
    send_byte(8'hC3, 5);
    send_byte(8'h11, 5); send_byte(8'h22, 5); send_byte(8'h33, 5); send_byte(8'h44, 5);
    idle(4);
    chk("s2_strobes", 16'(n_strobe), 16'd4);
    chk("s2_err", 16'(n_err), 16'd0);
    chk("s2_hdr", 16'(hdr_type), 16'd1);
    chk("s2_done_byte", 16'(done_byte), 16'h44);

    // Noise ahead of the header; an A5 data byte is payload.
    scen_begin();
    send_byte(8'h5A, 0); send_byte(8'h3C, 0);
    chk("s3_noise_strobes", 16'(n_strobe), 16'd0);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'hA5, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    idle(4);
    chk("s3_strobes", 16'(n_strobe), 16'd4);
    chk("s3_done", 16'(n_done), 16'd1);
    chk("s3_hdr", 16'(hdr_type), 16'd0);

    // Gap timeout after two bytes, then a clean packet.
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    idle(GM + 1 + 3);
    chk("s4_err", 16'(n_err), 16'd1);
    chk("s4_strobes", 16'(n_strobe), 16'd2);
    chk("s4_busy", 16'(busy), 16'd0);
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    idle(4);
    chk("s4b_strobes", 16'(n_strobe), 16'd4);
    chk("s4b_done", 16'(n_done), 16'd1);

    // A gap of exactly GM idle clocks is tolerated.
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    idle(GM);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    idle(4);
    chk("s5_err", 16'(n_err), 16'd0);
    chk("s5_strobes", 16'(n_strobe), 16'd4);

    // Reset after 13 data bits abandons the packet silently.
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    for (int i = 7; i >= 3; i--) begin
      logic [7:0] t;
      t = 8'h22;
      step(1'b1, t[i], 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("s6_rst_busy", 16'(busy), 16'd0);
    chk("s6_rst_byte_out", 16'(byte_out), 16'h00);
    chk("s6_rst_idx", 16'(byte_idx), 16'd0);
    chk("s6_rst_err", 16'(pkt_err), 16'd0);
    idle(2);
    chk("s6_strobes_before", 16'(n_strobe), 16'd1);
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    idle(4);
    chk("s6_first_idx", 16'(first_idx), 16'd0);
    chk("s6_strobes", 16'(n_strobe), 16'd4);
    chk("s6_err", 16'(n_err), 16'd0);

    // Back-to-back packets.
    scen_begin();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    idle(4);
    chk("s7_strobes", 16'(n_strobe), 16'd8);
    chk("s7_done", 16'(n_done), 16'd2);

    // Random packets with random headers, payloads and short gaps.
    for (int p = 0; p < 4; p++) begin
      send_byte(($urandom_range(1, 0) == 0) ? 8'hA5 : 8'hC3, 3);
      for (int k = 0; k < NB; k++) send_byte(8'($urandom_range(255, 0)), 3);
      idle(3);
    end
    idle(GM + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
